// File: rtl/fu_pkg.sv
// Shared types and constants for the sequential functional unit.
// Op encodings, FSM states and the last legal select value.
package fu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LAND = 4'd6,
    OP_LOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_M3N  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } fsm_e;

  localparam logic [3:0] OP_LAST = 4'd11;

endpackage

// File: rtl/seq_functional_unit_if.sv
// Operand/result handshake bundle for seq_functional_unit.
// master: operand source + result sink; slave: the unit.
interface seq_functional_unit_if #(
  parameter int W = 4
);
  localparam int RW = 2 * W;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  m;
  logic [W-1:0]  n;
  logic [3:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out;
  logic          zero;
  logic          ovf;
  logic          err;
  logic          busy;

  modport master (
    output in_valid, m, n, sel, out_ready,
    input  in_ready, out_valid, out,
    input  zero, ovf, err, busy
  );

  modport slave (
    input  in_valid, m, n, sel, out_ready,
    output in_ready, out_valid, out,
    output zero, ovf, err, busy
  );

endinterface

// File: rtl/shift_add_mul.sv
// Iterative W-cycle shift-add multiplier, one bit of b per edge.
// Ports: start loads a/b; done marks the final edge; product = a*b then.
module shift_add_mul #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int RW = 2 * W;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] mc_q, mc_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [W-1:0]  mp_q, mp_d;
  logic [RW-1:0] sum;

  // sum already includes the current bit, so on the last
  // edge it is the finished product.
  always_comb begin
    sum   = acc_q + (mp_q[0] ? mc_q : '0);
    done  = run_q && (cnt_q == LAST);
    run_d = run_q;
    cnt_d = cnt_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    acc_d = acc_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      mc_d  = RW'(a);
      mp_d  = b;
      acc_d = '0;
    end else if (run_q) begin
      acc_d = sum;
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (done) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  assign product = sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/seq_functional_unit.sv
// Registered W-bit functional unit with valid/ready in and out.
// Ports: clk, rst_n, bus (slave: operands, result, flags, busy).
module seq_functional_unit
  import fu_pkg::*;
#(
  parameter int W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_functional_unit_if.slave bus
);

  localparam int RW = 2 * W;
  localparam logic [RW-1:0] RWV = RW'(RW);

  fsm_e          state_q, state_d;
  logic          ov_q, ov_d;
  logic [RW-1:0] out_q, out_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic            accept;
  logic            start;
  logic            done;
  logic [RW-1:0]   prod;
  logic [RW-1:0]   me, ne, res;
  logic            rovf, rerr;
  logic [2*RW-1:0] shl_w;

  assign me = RW'(bus.m);
  assign ne = RW'(bus.n);

  always_comb begin
    res   = '0;
    rovf  = 1'b0;
    rerr  = 1'b0;
    shl_w = (2 * RW)'(me) << bus.n;
    unique case (bus.sel)
      OP_ADD: begin
        res  = me + ne;
        rovf = |res[RW-1:W];
      end
      OP_SUB: begin
        res  = me - ne;
        rovf = bus.m < bus.n;
      end
      OP_MUL:  res = '0;
      OP_AND:  res = me & ne;
      OP_OR:   res = me | ne;
      OP_XOR:  res = me ^ ne;
      OP_LAND: res = RW'((|bus.m) && (|bus.n));
      OP_LOR:  res = RW'((|bus.m) || (|bus.n));
      OP_NOT:  res = ~me;
      OP_M3N: begin
        res  = (me << 1) + me - ne;
        rovf = |res[RW-1:W];
      end
      OP_SHL: begin
        // Past RW every set bit of m falls off the top.
        if (ne >= RWV) begin
          res  = '0;
          rovf = |bus.m;
        end else begin
          res  = shl_w[RW-1:0];
          rovf = |shl_w[2*RW-1:RW];
        end
      end
      OP_SHR:  res = me >> bus.n;
      default: rerr = 1'b1;
    endcase
  end

  assign bus.in_ready = (state_q == IDLE)
                     && (!ov_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign start  = accept && (bus.sel == OP_MUL);

  shift_add_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (bus.m),
    .b       (bus.n),
    .done    (done),
    .product (prod)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fresh result wins over draining; otherwise hold until taken.
  always_comb begin
    ov_d   = ov_q;
    out_d  = out_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    if (accept && !start) begin
      ov_d   = 1'b1;
      out_d  = res;
      zero_d = (res == '0);
      ovf_d  = rovf;
      err_d  = rerr;
    end else if (done) begin
      ov_d   = 1'b1;
      out_d  = prod;
      zero_d = (prod == '0);
      ovf_d  = |prod[RW-1:W];
      err_d  = 1'b0;
    end else if (ov_q && bus.out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == MUL);

endmodule

// File: tb/tb_seq_functional_unit.sv
// Self-checking bench for seq_functional_unit at W=4 and W=8.
// Directed plan cases plus randomized ops against a behavioural model.
module tb_seq_functional_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       iv = 1'b0;
  logic       ordy = 1'b1;
  logic       w8 = 1'b0;
  logic [7:0] mm = '0;
  logic [7:0] nn = '0;
  logic [3:0] ss = '0;

  seq_functional_unit_if #(.W(4)) b4 ();
  seq_functional_unit_if #(.W(8)) b8 ();

  assign b4.in_valid  = iv & ~w8;
  assign b4.m         = mm[3:0];
  assign b4.n         = nn[3:0];
  assign b4.sel       = ss;
  assign b4.out_ready = ordy;
  assign b8.in_valid  = iv & w8;
  assign b8.m         = mm;
  assign b8.n         = nn;
  assign b8.sel       = ss;
  assign b8.out_ready = ordy;

  seq_functional_unit #(.W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  seq_functional_unit #(.W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  logic        o_valid, o_rdy, o_zero, o_ovf, o_err, o_busy;
  logic [15:0] o_out;
  assign o_valid = w8 ? b8.out_valid : b4.out_valid;
  assign o_rdy   = w8 ? b8.in_ready  : b4.in_ready;
  assign o_zero  = w8 ? b8.zero      : b4.zero;
  assign o_ovf   = w8 ? b8.ovf       : b4.ovf;
  assign o_err   = w8 ? b8.err       : b4.err;
  assign o_busy  = w8 ? b8.busy      : b4.busy;
  assign o_out   = w8 ? b8.out       : {8'h00, b4.out};

  // Reference: plain arithmetic on zero-extended operands mod 2^(2w).
  function automatic void model(
    input  int              w,
    input  int              s,
    input  longint unsigned a,
    input  longint unsigned b,
    output longint unsigned r,
    output bit              z,
    output bit              o,
    output bit              e
  );
    int rw;
    longint unsigned mask;
    longint unsigned full;
    rw = 2 * w;
    mask = (64'd1 << rw) - 1;
    r = 0; o = 0; e = 0;
    case (s)
      0: begin r = (a + b) & mask; o = (r >> w) != 0; end
      1: begin r = (a - b) & mask; o = a < b; end
      2: begin r = (a * b) & mask; o = (r >> w) != 0; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (a != 0 && b != 0) ? 1 : 0;
      7: r = (a != 0 || b != 0) ? 1 : 0;
      8: r = ~a & mask;
      9: begin r = (3 * a - b) & mask; o = (r >> w) != 0; end
      10: begin
        if (b >= longint'(rw)) begin
          r = 0; o = a != 0;
        end else begin
          full = a << b;
          r = full & mask;
          o = (full >> rw) != 0;
        end
      end
      11: r = a >> b;
      default: begin r = 0; e = 1; end
    endcase
    z = (r == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait (bounded) for in_ready, take the accept edge.
  task automatic issue(input logic [3:0] s,
                       input logic [7:0] a,
                       input logic [7:0] b);
    int k;
    iv = 1'b1; ss = s; mm = a; nn = b;
    k = 0;
    while (!o_rdy && k < 50) begin
      tick();
      k++;
    end
    if (!o_rdy) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready stayed %b, required 1", o_rdy);
    end
    tick();
    iv = 1'b0;
    ss = 4'($urandom);
    mm = 8'($urandom);
    nn = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b4.out, b4.out_valid, b4.zero, b4.ovf, b4.err, b4.busy} !== '0) begin
      errors++;
      $display("FAIL reset4: got out=%h v=%b z=%b o=%b e=%b b=%b, required all 0",
               b4.out, b4.out_valid, b4.zero, b4.ovf, b4.err, b4.busy);
    end
    checks++;
    if ({b8.out, b8.out_valid, b8.zero, b8.ovf, b8.err, b8.busy} !== '0) begin
      errors++;
      $display("FAIL reset8: got out=%h v=%b, required all 0",
               b8.out, b8.out_valid);
    end
    checks++;
    if (b4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: got %b, required 1", b4.in_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed(input bit wide);
    logic [3:0]  ts [4] = '{4'd0, 4'd1, 4'd8, 4'd9};
    logic [7:0]  ta [4] = '{8'd15, 8'd3, 8'd3, 8'd2};
    logic [7:0]  tb [4] = '{8'd15, 8'd5, 8'd0, 8'd7};
    logic [15:0] e4 [4] = '{16'h1E, 16'hFE, 16'hFC, 16'hFF};
    logic [15:0] e8 [4] = '{16'h1E, 16'hFFFE, 16'hFFFC, 16'hFFFF};
    logic        v4 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        v8 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] eo;
    logic        ev;
    w8 = wide; ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eo = wide ? e8[i] : e4[i];
      ev = wide ? v8[i] : v4[i];
      issue(ts[i], ta[i], tb[i]);
      checks++;
      if ({o_valid, o_out, o_ovf, o_zero, o_err} !== {1'b1, eo, ev, 2'b00}) begin
        errors++;
        $display("FAIL directed w8=%0d sel=%0d: got v=%b out=%h ovf=%b z=%b e=%b, required v=1 out=%h ovf=%b z=0 e=0",
                 wide, ts[i], o_valid, o_out, o_ovf, o_zero, o_err, eo, ev);
      end
    end
    tick();
  endtask

  task automatic test_mul(input bit wide, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] eo);
    int w, cyc, bcnt, rcnt;
    w = wide ? 8 : 4;
    w8 = wide; ordy = 1'b1;
    issue(4'd2, a, b);
    // A second op is held (and its fields wiggle) during the multiply.
    iv = 1'b1; ss = 4'd0; mm = 8'd1; nn = 8'd2;
    cyc = 0; bcnt = 0; rcnt = 0;
    while (!o_valid && cyc < 40) begin
      if (o_busy) bcnt++;
      if (o_rdy) rcnt++;
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== w || bcnt !== w || rcnt !== 0) begin
      errors++;
      $display("FAIL mul_timing w=%0d: got edges=%0d busy=%0d rdy=%0d, required %0d/%0d/0",
               w, cyc, bcnt, rcnt, w, w);
    end
    checks++;
    if ({o_valid, o_out, o_ovf, o_busy} !== {1'b1, eo, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul_result w=%0d: got v=%b out=%h ovf=%b busy=%b, required v=1 out=%h ovf=1 busy=0",
               w, o_valid, o_out, o_ovf, o_busy, eo);
    end
    tick();
    iv = 1'b0;
    checks++;
    if ({o_valid, o_out} !== {1'b1, 16'h0003}) begin
      errors++;
      $display("FAIL mul_followon w=%0d: got v=%b out=%h, required v=1 out=0003",
               w, o_valid, o_out);
    end
    tick();
  endtask

  task automatic test_backpressure();
    w8 = 1'b0; ordy = 1'b0;
    issue(4'd0, 8'd15, 8'd15);
    iv = 1'b1; ss = 4'd3; mm = 8'd12; nn = 8'd10;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_valid, o_out, o_rdy} !== {1'b1, 16'h001E, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d: got v=%b out=%h rdy=%b, required v=1 out=001e rdy=0",
                 i, o_valid, o_out, o_rdy);
      end
      tick();
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy: got %b, required 1", o_rdy);
    end
    tick();
    iv = 1'b0;
    checks++;
    if ({o_valid, o_out, o_ovf} !== {1'b1, 16'h0008, 1'b0}) begin
      errors++;
      $display("FAIL bp_and: got v=%b out=%h ovf=%b, required v=1 out=0008 ovf=0",
               o_valid, o_out, o_ovf);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b, required 0", o_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    w8 = 1'b0; ordy = 1'b1;
    issue(4'd2, 8'd15, 8'd15);
    tick();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rmm_busy: got %b, required 1", o_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_out, o_valid, o_zero, o_ovf, o_err, o_busy} !== '0) begin
      errors++;
      $display("FAIL rmm_clear: got out=%h v=%b z=%b o=%b e=%b b=%b, required all 0",
               o_out, o_valid, o_zero, o_ovf, o_err, o_busy);
    end
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid || o_busy) seen = 1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rmm_ghost: got result/busy after reset=%b, required 0", seen);
    end
    issue(4'd13, 8'd9, 8'd3);
    checks++;
    if ({o_valid, o_out, o_err, o_zero, o_ovf} !== {1'b1, 16'h0, 3'b110}) begin
      errors++;
      $display("FAIL bad_sel: got v=%b out=%h e=%b z=%b o=%b, required v=1 out=0 e=1 z=1 o=0",
               o_valid, o_out, o_err, o_zero, o_ovf);
    end
    tick();
  endtask

  task automatic test_shl8();
    w8 = 1'b1; ordy = 1'b1;
    issue(4'd10, 8'd1, 8'd16);
    checks++;
    if ({o_valid, o_out, o_ovf, o_zero} !== {1'b1, 16'h0, 2'b11}) begin
      errors++;
      $display("FAIL shl8_far: got v=%b out=%h ovf=%b z=%b, required v=1 out=0 ovf=1 z=1",
               o_valid, o_out, o_ovf, o_zero);
    end
    issue(4'd10, 8'h81, 8'd9);
    checks++;
    if ({o_out, o_ovf} !== {16'h0200, 1'b1}) begin
      errors++;
      $display("FAIL shl8_edge: got out=%h ovf=%b, required out=0200 ovf=1",
               o_out, o_ovf);
    end
    tick();
  endtask

  task automatic test_random(input bit wide, input int cnt);
    longint unsigned r;
    bit z, o, e;
    int w, k, hold;
    logic [7:0] a, b;
    logic [3:0] s;
    w = wide ? 8 : 4;
    w8 = wide; ordy = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      s = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      if (!wide) begin
        a[7:4] = '0;
        b[7:4] = '0;
      end
      model(w, int'(s), longint'(a), longint'(b), r, z, o, e);
      issue(s, a, b);
      k = 0;
      while (!o_valid && k < 40) begin
        tick();
        k++;
      end
      checks++;
      if ({o_valid, o_out, o_zero, o_ovf, o_err} !== {1'b1, r[15:0], z, o, e}) begin
        errors++;
        $display("FAIL rand w=%0d sel=%0d m=%0d n=%0d: got v=%b out=%h z=%b o=%b e=%b, required v=1 out=%h z=%b o=%b e=%b",
                 w, s, a, b, o_valid, o_out, o_zero, o_ovf, o_err, r[15:0], z, o, e);
      end
      hold = $urandom_range(0, 2);
      ordy = 1'b0;
      for (int j = 0; j < hold; j++) begin
        tick();
        checks++;
        if ({o_valid, o_out, o_ovf} !== {1'b1, r[15:0], o}) begin
          errors++;
          $display("FAIL rand_hold w=%0d: got v=%b out=%h ovf=%b, required v=1 out=%h ovf=%b",
                   w, o_valid, o_out, o_ovf, r[15:0], o);
        end
      end
      ordy = 1'b1;
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed(1'b0);
    test_mul(1'b0, 8'd15, 8'd15, 16'h00E1);
    test_backpressure();
    test_reset_mid_mul();
    test_directed(1'b1);
    test_mul(1'b1, 8'd200, 8'd100, 16'h4E20);
    test_shl8();
    test_random(1'b0, 150);
    test_random(1'b1, 150);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
